// File: rtl/data_mem_resp.sv
// Word-addressed data memory with combinational read, byte-lane writes and a write-trace FIFO.
// Optional range checking is enabled by defining DM_ADDR_CHECK_EN.
module data_mem_resp #(
  parameter int DEPTH_WORDS = 4096,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic [3:0]  trace_byteen,
  output logic        trace_overflow,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byteen;
  } entry_t;

  logic [31:0]   mem_q [DEPTH_WORDS];
  entry_t        fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [31:0]   merged;
  logic          in_range;
  logic          wr_en, pop, full, push_ok, drop;
  entry_t        new_entry, head;

  assign word_idx = m_data_addr[AW+1:2];
  assign rd_word  = mem_q[word_idx];

`ifdef DM_ADDR_CHECK_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  logic err_q;

  assign in_range = ({1'b0, m_data_addr} < ADDR_LIMIT);
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (!in_range) begin
      err_q <= 1'b1;
    end
  end
`else
  assign in_range = 1'b1;
  assign err      = 1'b0;
`endif

  assign m_data_rdata = in_range ? rd_word : 32'h0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged[8*gi +: 8] = m_data_byteen[gi] ? m_data_wdata[8*gi +: 8] : rd_word[8*gi +: 8];
  end

  assign wr_en = reset && (m_data_byteen != 4'b0000) && in_range;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (wr_en) begin
      mem_q[word_idx] <= merged;
    end
  end

  assign new_entry.pc     = m_inst_addr;
  assign new_entry.addr   = m_data_addr & ~32'h3;
  assign new_entry.data   = merged;
  assign new_entry.byteen = m_data_byteen;

  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  always_comb begin
    pop        = (count_q != '0) && trace_ready;
    full       = (count_q == CW'(FIFO_DEPTH));
    push_ok    = wr_en && (!full || pop);
    drop       = wr_en && full && !pop;
    wptr_d     = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
    overflow_d = overflow_q | drop;
    count_d    = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wptr_q] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign head           = fifo_q[rptr_q];
  assign trace_valid    = (count_q != '0);
  assign trace_pc       = head.pc;
  assign trace_addr     = head.addr;
  assign trace_data     = head.data;
  assign trace_byteen   = head.byteen;
  assign trace_overflow = overflow_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed self-checking bench for data_mem_resp (default build; DM_ADDR_CHECK_EN selects the range-check expectations).
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m_data_addr = '0;
  logic [31:0] m_data_wdata = '0;
  logic [3:0]  m_data_byteen = '0;
  logic [31:0] m_inst_addr = '0;
  logic [31:0] m_data_rdata;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [31:0] trace_pc, trace_addr, trace_data;
  logic [3:0]  trace_byteen;
  logic        trace_overflow;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_resp #(.DEPTH_WORDS(4096), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
    .m_data_rdata(m_data_rdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_byteen(trace_byteen), .trace_overflow(trace_overflow), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic [31:0] pc);
    m_data_addr   = a;
    m_data_wdata  = d;
    m_data_byteen = be;
    m_inst_addr   = pc;
    tick();
    m_data_byteen = 4'b0000;
  endtask

  task automatic pop_one();
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    m_data_addr = a;
    #1;
    check(tag, m_data_rdata, exp);
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_valid_first_edge", {31'b0, trace_valid}, 32'h0);
    tick();
    check("rst_overflow", {31'b0, trace_overflow}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    rd("rst_rdata_10", 32'h10, 32'h0);
    reset = 1'b1;
    tick();

    // Full-word write; read shows old contents before the edge
    m_data_addr = 32'h10; m_data_wdata = 32'h12345678; m_data_byteen = 4'hF; m_inst_addr = 32'h3008;
    #1;
    check("rdw_pre_edge", m_data_rdata, 32'h0);
    tick();
    m_data_byteen = 4'b0000;
    $display("write addr=0x10 data=0x12345678 be=F pc=0x3008");
    rd("word_write_rdata", 32'h10, 32'h12345678);
    check("t1_valid", {31'b0, trace_valid}, 32'h1);
    check("t1_pc", trace_pc, 32'h3008);
    check("t1_addr", trace_addr, 32'h10);
    check("t1_data", trace_data, 32'h12345678);
    check("t1_be", {28'b0, trace_byteen}, 32'hF);

    // Single-lane merge with unaligned address bits
    wr(32'h13, 32'h00AB0000, 4'b0100, 32'h300C);
    $display("write addr=0x13 data=0x00AB0000 be=4 pc=0x300C");
    rd("merge_rdata", 32'h10, 32'h12AB5678);
    check("head_stable_pc", trace_pc, 32'h3008);
    check("head_stable_data", trace_data, 32'h12345678);
    pop_one();
    check("t2_pc", trace_pc, 32'h300C);
    check("t2_addr", trace_addr, 32'h10);
    check("t2_data", trace_data, 32'h12AB5678);
    check("t2_be", {28'b0, trace_byteen}, 32'h4);
    pop_one();
    check("drained_valid", {31'b0, trace_valid}, 32'h0);
    pop_one();
    check("empty_pop_valid", {31'b0, trace_valid}, 32'h0);

    // Address beyond the array
    wr(32'h4000, 32'hCAFEF00D, 4'hF, 32'h3010);
    $display("write addr=0x4000 data=0xCAFEF00D be=F pc=0x3010");
`ifdef DM_ADDR_CHECK_EN
    check("oor_err", {31'b0, err}, 32'h1);
    check("oor_no_push", {31'b0, trace_valid}, 32'h0);
    rd("oor_rdata", 32'h4000, 32'h0);
    rd("oor_word0", 32'h0, 32'h0);
`else
    check("alias_err", {31'b0, err}, 32'h0);
    check("alias_push_addr", trace_addr, 32'h4000);
    rd("alias_word0", 32'h0, 32'hCAFEF00D);
    pop_one();
    check("alias_drained", {31'b0, trace_valid}, 32'h0);
`endif

    // Overflow: nine writes with the consumer stalled
    for (int k = 0; k < 9; k++) begin
      wr(32'h100 + 32'(4*k), 32'hA0000000 + 32'(k), 4'hF, 32'h4000 + 32'(4*k));
      $display("write addr=0x%0h data=0x%0h be=F", 32'h100 + 32'(4*k), 32'hA0000000 + 32'(k));
    end
    check("ovf_flag", {31'b0, trace_overflow}, 32'h1);
    check("ovf_head_pc", trace_pc, 32'h4000);
    rd("ovf_9th_in_mem", 32'h120, 32'hA0000008);
    for (int k = 0; k < 8; k++) begin
      check("ovf_drain_valid", {31'b0, trace_valid}, 32'h1);
      check("ovf_drain_data", trace_data, 32'hA0000000 + 32'(k));
      pop_one();
    end
    check("ovf_drain_empty", {31'b0, trace_valid}, 32'h0);
    check("ovf_sticky", {31'b0, trace_overflow}, 32'h1);

    // Reset with three queued entries, writes driven during reset ignored
    for (int k = 0; k < 3; k++) wr(32'h10, 32'h5555AAA0 + 32'(k), 4'hF, 32'h5000);
    m_data_addr = 32'h20; m_data_wdata = 32'hDEADBEEF; m_data_byteen = 4'hF;
    reset = 1'b0;
    tick();
    check("mid_rst_valid", {31'b0, trace_valid}, 32'h0);
    check("mid_rst_overflow", {31'b0, trace_overflow}, 32'h0);
    tick();
    m_data_byteen = 4'b0000;
    reset = 1'b1;
    rd("mid_rst_rdata_10", 32'h10, 32'h0);
    rd("rst_write_ignored", 32'h20, 32'h0);
    tick();
    check("post_rst_valid", {31'b0, trace_valid}, 32'h0);

    // Full FIFO with simultaneous push and pop
    for (int k = 0; k < 8; k++) wr(32'h200 + 32'(4*k), 32'hB0000000 + 32'(k), 4'hF, 32'h6000 + 32'(4*k));
    check("full_no_ovf", {31'b0, trace_overflow}, 32'h0);
    trace_ready = 1'b1;
    wr(32'h220, 32'hB0000008, 4'hF, 32'h6020);
    trace_ready = 1'b0;
    $display("write addr=0x220 data=0xB0000008 be=F with pop while full");
    check("pushpop_no_ovf", {31'b0, trace_overflow}, 32'h0);
    check("pushpop_head", trace_data, 32'hB0000001);
    for (int k = 1; k < 9; k++) begin
      check("pushpop_drain_valid", {31'b0, trace_valid}, 32'h1);
      check("pushpop_drain_data", trace_data, 32'hB0000000 + 32'(k));
      pop_one();
    end
    check("pushpop_tail_pc_empty", {31'b0, trace_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The parameter DEPTH_WORDS SHALL default to 4096 and set the memory depth in 32-bit words; it SHALL be a power of two.
REQ-002 The parameter FIFO_DEPTH SHALL default to 8 and set the write-trace FIFO depth in entries; it SHALL be a power of two and at least 2.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide: synchronous, active-low reset.
REQ-005 Port m_data_addr SHALL be an input, 32 bits wide: CPU data byte address.
REQ-006 Port m_data_wdata SHALL be an input, 32 bits wide: CPU store data, already lane-aligned.
REQ-007 Port m_data_byteen SHALL be an input, 4 bits wide: per-byte write enables; 4'b0000 means no write.
REQ-008 Port m_inst_addr SHALL be an input, 32 bits wide: PC of the instruction in M stage.
REQ-009 Port m_data_rdata SHALL be an output, 32 bits wide: word at the addressed location.
REQ-010 Port trace_valid SHALL be an output, 1 bit wide: the trace FIFO head entry is valid.
REQ-011 Port trace_ready SHALL be an input, 1 bit wide: the consumer accepts the head entry.
REQ-012 Port trace_pc SHALL be an output, 32 bits wide: m_inst_addr of the logged store.
REQ-013 Port trace_addr SHALL be an output, 32 bits wide: word-aligned store address (bits [1:0] = 0).
REQ-014 Port trace_data SHALL be an output, 32 bits wide: full word after the byte merge.
REQ-015 Port trace_byteen SHALL be an output, 4 bits wide: byte enables of the logged store.
REQ-016 Port trace_overflow SHALL be an output, 1 bit wide: sticky flag, set when a trace entry is dropped.
REQ-017 Port err SHALL be an output, 1 bit wide: sticky out-of-range flag (see Configuration).

Function
REQ-018 Word index SHALL be m_data_addr[log2(DEPTH_WORDS)+1:2]; bits [1:0] SHALL be ignored for indexing.
REQ-019 m_data_rdata SHALL be combinational from the current array contents, with zero-cycle latency in the same cycle as the address.
REQ-020 When m_data_byteen != 0 on a rising edge, each byte lane i with byteen[i]=1 SHALL take wdata[8i+7:8i]; other lanes SHALL hold their value.
REQ-021 On read-during-write to the same word, m_data_rdata SHALL show pre-edge contents in that cycle and merged contents from the next cycle.
REQ-022 Every performed write SHALL push {m_inst_addr, aligned addr, merged word, byteen} into the trace FIFO on the same edge.
REQ-023 A pop SHALL occur on an edge where trace_valid and trace_ready are both 1; trace_valid SHALL equal (count != 0).
REQ-024 trace_* outputs SHALL be driven from the head entry and SHALL remain stable while trace_valid=1 and trace_ready=0.
REQ-025 Push and pop on the same edge SHALL leave count unchanged, including when full or when count=1.
REQ-026 A push while full without a simultaneous pop SHALL drop the new entry, still perform the memory write, and set trace_overflow.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-028 A pop with count=0 SHALL be ignored.

Reset
REQ-029 While reset=0 at a rising edge, all memory words, FIFO pointers, count, trace_overflow and err SHALL clear to 0.
REQ-030 During reset, CPU writes SHALL be ignored and no trace entry SHALL be pushed; trace_valid SHALL read 0 from the first edge after reset is asserted.
REQ-031 Reset asserted mid-drain SHALL discard all queued entries.

Configuration
REQ-032 With DM_ADDR_CHECK_EN defined, an access (read or write) with m_data_addr >= 4*DEPTH_WORDS SHALL set err, suppress the write and trace push, and return m_data_rdata = 0.
REQ-033 Without DM_ADDR_CHECK_EN, addresses SHALL alias modulo 4*DEPTH_WORDS and err SHALL be tied to 0.

Verification
REQ-034 Write addr 0x10, byteen 4'b1111, wdata 0x12345678, PC 0x3008 -> next cycle rdata@0x10 = 0x12345678; trace entry {0x3008, 0x10, 0x12345678, 4'hF}.
REQ-035 Write 0x10 byteen 4'b0100 wdata 0x00AB0000 after REQ-034 -> rdata = 0x12AB5678; trace_data = 0x12AB5678.
REQ-036 With trace_ready=0, issue 9 writes (FIFO_DEPTH=8) -> count=8, trace_overflow=1, 9th word in memory, head = 1st write.
REQ-037 With FIFO full, write and trace_ready=1 on the same edge -> count stays 8, no overflow, new entry at the tail.
REQ-038 With DM_ADDR_CHECK_EN defined, write addr 0x4000 (DEPTH_WORDS=4096) -> err=1, word 0 unchanged, no push; without the macro, word 0 is written.
REQ-039 Assert reset=0 with 3 queued entries -> trace_valid=0, trace_overflow=0, rdata@0x10 = 0 after the edge.
